// File: rtl/alu_pkg.sv
// Shared opcode map and status-flag payload for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NAND = 3'b110;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b111;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and Z/N/C/V flags for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y_c,
    output alu_flags_t       o_flags_c
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // Extra top bit carries the carry-out (add) or borrow (subtract).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Operation select and flag generation.
    always_comb begin
        o_y_c     = '0;
        o_flags_c = '0;
        case (i_op)
            OP_ADD: begin
                o_y_c       = w_sum[WIDTH-1:0];
                o_flags_c.c = w_sum[WIDTH];
                o_flags_c.v = (i_a[MSB] == i_b[MSB]) & (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_y_c       = w_diff[WIDTH-1:0];
                o_flags_c.c = w_diff[WIDTH];
                o_flags_c.v = (i_a[MSB] != i_b[MSB]) & (w_diff[MSB] != i_a[MSB]);
            end
            OP_AND:  o_y_c = i_a & i_b;
            OP_OR:   o_y_c = i_a | i_b;
            OP_XOR:  o_y_c = i_a ^ i_b;
            OP_XNOR: o_y_c = ~(i_a ^ i_b);
            OP_NAND: o_y_c = ~(i_a & i_b);
            OP_NOR:  o_y_c = ~(i_a | i_b);
        endcase
        o_flags_c.z = (o_y_c == '0);
        o_flags_c.n = o_y_c[MSB];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with a chaining accumulator.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [WIDTH-1:0] acc
);

    logic             r_s1_valid;
    logic [OP_W-1:0]  r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_acc_en;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    alu_flags_t       r_flags;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_core_a;
    logic [WIDTH-1:0] w_core_y;
    alu_flags_t       w_core_flags;

    assign w_s2_adv  = !r_out_valid | out_ready;
    assign w_s1_adv  = !r_s1_valid | w_s2_adv;
    assign w_s2_load = w_s2_adv & r_s1_valid;
    // The accumulator is read at the same load that writes it, so chained beats need no forwarding.
    assign w_core_a  = r_s1_acc_en ? r_acc : r_s1_a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op      (r_s1_op),
        .i_a       (w_core_a),
        .i_b       (r_s1_b),
        .o_y_c     (w_core_y),
        .o_flags_c (w_core_flags)
    );

    // Stage 1: capture the operand beat whenever the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_acc_en <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op     <= opcode;
                r_s1_a      <= a;
                r_s1_b      <= b;
                r_s1_acc_en <= acc_en;
            end
        end
    end

    // Stage 2: register result and flags; hold everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y     <= w_core_y;
                r_flags <= w_core_flags;
            end
        end
    end

    // Accumulator: clear wins over a write-back from the loading beat.
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            r_acc <= '0;
        end else if (w_s2_load && r_s1_acc_en) begin
            r_acc <= w_core_y;
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flag_z    = r_flags.z;
    assign flag_n    = r_flags.n;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;
    assign acc       = r_acc;

endmodule
